muxtree_req_stage: RTL and testbench

// - Registered request stage directly upstream of the 4-way case/priority mux-tree datapath.
// - Accepts one request per cycle over valid/ready and buffers up to 2 entries (skid buffer).
// - Each request carries: selector, per-lane priority bits B/B2, and lane operands C/D/E.
// - Forwards only selectors the mux decodes (sel < LANES), so the mux never sees an unmatched case.

---
 rtl/muxtree_req_stage_pkg.sv | 36 +++
 rtl/muxtree_req_stage_if.sv | 27 ++
 rtl/muxtree_req_stage_skid_buf.sv | 97 +++++++++
 rtl/muxtree_req_stage.sv | 126 ++++++++++++
 tb/tb_muxtree_req_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/muxtree_req_stage_pkg.sv
// -----------------------------------------------------------------------------
// muxtree_pkg
// Shared types and helpers for the request stage that feeds the 4-way
// case/priority mux-tree datapath.
//   N_DEF / LANES_DEF / CNT_W_DEF : default selector width, lane count and
//                                   drop-counter width
//   lane_t                        : one lane operand / selector word
//   muxtree_req_t                 : one request as stored in the skid buffer
//   sel_in_range()                : true when the mux decodes the selector
// -----------------------------------------------------------------------------
package muxtree_pkg;

    localparam int N_DEF     = 4;
    localparam int LANES_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [N_DEF-1:0] lane_t;

    // Lane i of c/d/e is element [i]; the packed layout matches the flat
    // {lane LANES-1, ..., lane 0} bus packing on the ports.
    typedef struct packed {
        lane_t                 sel;
        lane_t                 b;
        lane_t                 b2;
        lane_t [LANES_DEF-1:0] c;
        lane_t [LANES_DEF-1:0] d;
        lane_t [LANES_DEF-1:0] e;
    } muxtree_req_t;

    // The mux only has case items for 0 .. lanes-1.
    function automatic logic sel_in_range(input logic [31:0] sel,
                                          input int unsigned lanes);
        return (sel < lanes);
    endfunction

endpackage

// File: rtl/muxtree_req_stage_if.sv
// -----------------------------------------------------------------------------
// muxtree_req_stage_if
// Valid/ready request bus into and out of the mux-tree request stage.
//   valid / ready : handshake (transfer when both high on posedge clk)
//   sel           : lane selector, N bits
//   b / b2        : per-lane outer / inner priority bits, bit i for lane i
//   c / d / e     : lane operands, lane i at [i*N +: N]
// Modports: master drives the request, slave returns ready.
// -----------------------------------------------------------------------------
interface muxtree_req_stage_if
    import muxtree_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LANES = LANES_DEF
);
    logic               valid;
    logic               ready;
    logic [N-1:0]       sel;
    logic [N-1:0]       b;
    logic [N-1:0]       b2;
    logic [LANES*N-1:0] c;
    logic [LANES*N-1:0] d;
    logic [LANES*N-1:0] e;

    modport master (output valid, sel, b, b2, c, d, e, input ready);
    modport slave  (input  valid, sel, b, b2, c, d, e, output ready);
endinterface

// File: rtl/muxtree_req_stage_skid_buf.sv
// -----------------------------------------------------------------------------
// muxtree_skid_buf
// Generic 2-entry valid/ready FIFO. The head entry drives out_data directly,
// so an accepted entry is visible the cycle after it is written and stays
// stable while the consumer stalls.
// Ports:
//   clk, rst (async, active-low), flush (sync clear of all entries)
//   in_valid / in_ready / in_data    : write side
//   out_valid / out_ready / out_data : read side (head entry)
// in_ready depends only on occupancy; a full buffer never accepts, even in a
// cycle where the head is being consumed.
// -----------------------------------------------------------------------------
module muxtree_skid_buf
    import muxtree_pkg::*;
#(
    parameter type T = muxtree_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e state_q, state_d;
    T     head_q,  head_d;
    T     tail_q,  tail_d;
    logic push;
    logic pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;

        if (flush) begin
            // Entry data is left in place; only occupancy matters once empty.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    unique case ({push, pop})
                        2'b11: head_d = in_data;        // old head leaves, new one takes over
                        2'b10: begin
                            tail_d  = in_data;
                            state_d = FULL;
                        end
                        2'b01: state_d = EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign out_data = head_q;

endmodule

// File: rtl/muxtree_req_stage.sv
// -----------------------------------------------------------------------------
// muxtree_req_stage
// Registered request stage in front of the 4-way case/priority mux tree.
// Requests are buffered (2 deep) and only selectors the mux decodes
// (sel < LANES) are ever presented on out_if.
// Ports:
//   clk            clock, all state on posedge
//   rst            asynchronous active-low reset
//   flush          synchronous clear of buffered requests (drop_cnt kept)
//   in_if  (slave) incoming request bus: valid/ready, sel, b, b2, c, d, e
//   out_if (master) head entry toward the mux stage
//   drop_cnt       saturating count of out-of-range selectors seen
// Build option MUXREQ_SEL_CLAMP_EN:
//   undefined : out-of-range requests are consumed and discarded
//   defined   : out-of-range requests are forwarded with sel = LANES-1
//   Either way each such request bumps drop_cnt.
// -----------------------------------------------------------------------------
module muxtree_req_stage
    import muxtree_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LANES = LANES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    muxtree_req_stage_if.slave  in_if,
    muxtree_req_stage_if.master out_if,
    output logic [CNT_W-1:0]    drop_cnt
);

    // Same layout as muxtree_req_t, sized by this instance's parameters.
    typedef struct packed {
        logic [N-1:0]            sel;
        logic [N-1:0]            b;
        logic [N-1:0]            b2;
        logic [LANES-1:0][N-1:0] c;
        logic [LANES-1:0][N-1:0] d;
        logic [LANES-1:0][N-1:0] e;
    } req_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    req_t             req_in;
    req_t             req_buf;
    req_t             req_head;
    logic             in_range;
    logic             fwd;
    logic             accept;
    logic             buf_in_valid;
    logic             buf_in_ready;
    logic             buf_out_valid;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        req_in.sel = in_if.sel;
        req_in.b   = in_if.b;
        req_in.b2  = in_if.b2;
        req_in.c   = in_if.c;
        req_in.d   = in_if.d;
        req_in.e   = in_if.e;

        in_range = sel_in_range(32'(in_if.sel), LANES);
        req_buf  = req_in;
`ifdef MUXREQ_SEL_CLAMP_EN
        fwd = 1'b1;
        if (!in_range) begin
            req_buf.sel = N'(LANES - 1);
        end
`else
        fwd = in_range;
`endif
    end

    // A dropped request still completes its handshake; it just never
    // reaches the buffer.
    assign buf_in_valid = in_if.valid & fwd;
    assign in_if.ready  = buf_in_ready;

    // Counted on the handshake itself, so a flush in the same cycle does
    // not hide an out-of-range selector.
    assign accept = in_if.valid & buf_in_ready;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !in_range) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

    muxtree_skid_buf #(
        .T (req_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (req_buf),
        .out_valid (buf_out_valid),
        .out_ready (out_if.ready),
        .out_data  (req_head)
    );

    assign out_if.valid = buf_out_valid;
    assign out_if.sel   = req_head.sel;
    assign out_if.b     = req_head.b;
    assign out_if.b2    = req_head.b2;
    assign out_if.c     = req_head.c;
    assign out_if.d     = req_head.d;
    assign out_if.e     = req_head.e;

endmodule

// File: tb/tb_muxtree_req_stage.sv
// -----------------------------------------------------------------------------
// tb_muxtree_req_stage
// Directed and randomized checks of muxtree_req_stage (N=4, LANES=4, CNT_W=8)
// against a queue-based reference model. Honours MUXREQ_SEL_CLAMP_EN.
// -----------------------------------------------------------------------------
module tb_muxtree_req_stage;

    localparam int N     = 4;
    localparam int LANES = 4;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [3:0]  sel;
        logic [3:0]  b;
        logic [3:0]  b2;
        logic [15:0] c;
        logic [15:0] d;
        logic [15:0] e;
    } mreq_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] drop_cnt;

    muxtree_req_stage_if #(.N(N), .LANES(LANES)) in_if ();
    muxtree_req_stage_if #(.N(N), .LANES(LANES)) out_if ();

    muxtree_req_stage #(.N(N), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_if    (in_if),
        .out_if   (out_if),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of at most two requests plus a saturating count.
    mreq_t       mq[$];
    int unsigned mcnt;
    int unsigned total_cnt;
    int unsigned pass_cnt;
    int unsigned fail_cnt;
    int unsigned cnt_before;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        mreq_t r;
        bit    acc;
        bit    oor;
        if (!rst) begin
            mq.delete();
            mcnt = 0;
            return;
        end
        acc = in_if.valid && (mq.size() < 2);
        oor = (in_if.sel >= 4'(LANES));
        if (acc && oor && mcnt < 255) mcnt++;
        if (flush) begin
            mq.delete();
            return;
        end
        if (mq.size() > 0 && out_if.ready) void'(mq.pop_front());
        if (acc) begin
            r = '{sel: in_if.sel, b: in_if.b, b2: in_if.b2, c: in_if.c, d: in_if.d, e: in_if.e};
            if (!oor) begin
                mq.push_back(r);
            end else begin
`ifdef MUXREQ_SEL_CLAMP_EN
                r.sel = 4'(LANES - 1);
                mq.push_back(r);
`endif
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready", {63'd0, in_if.ready}, {63'd0, mq.size() < 2});
        chk("out_valid", {63'd0, out_if.valid}, {63'd0, mq.size() > 0});
        chk("drop_cnt", 64'(drop_cnt), 64'(mcnt));
        if (mq.size() > 0)
            chk("head", 64'({out_if.sel, out_if.b, out_if.b2, out_if.c, out_if.d, out_if.e}), 64'(mq[0]));
    endtask

    // Advance one clock: model follows the edge, outputs checked at negedge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_req(input logic v, input logic [3:0] s, input logic [3:0] b,
                           input logic [15:0] c, input logic [15:0] e);
        in_if.valid = v;
        in_if.sel   = s;
        in_if.b     = b;
        in_if.b2    = ~b;
        in_if.c     = c;
        in_if.d     = c ^ 16'h5a5a;
        in_if.e     = e;
    endtask

    task automatic drain();
        in_if.valid  = 1'b0;
        flush        = 1'b0;
        out_if.ready = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        mq.delete();
        mcnt = 0;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        mcnt      = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        out_if.ready = 1'b0;
        set_req(1'b0, 4'd0, 4'd0, 16'd0, 16'd0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_if.valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_if.ready}, 64'd1);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_out_sel", 64'(out_if.sel), 64'd0);
        rst = 1'b1;

        // Traffic, then asynchronous reset in the middle of a cycle
        out_if.ready = 1'b0;
        set_req(1'b1, 4'd9, 4'h3, 16'h1234, 16'h4321);
        cycle();
        set_req(1'b1, 4'd1, 4'h5, 16'h2222, 16'h3333);
        cycle();
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        mcnt = 0;
        chk("arst_out_valid", {63'd0, out_if.valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_if.ready}, 64'd1);
        chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        cycle();
        rst = 1'b1;
        set_req(1'b1, 4'd1, 4'h1, 16'h00f0, 16'h0);
        cycle();
        chk("post_rst_valid", {63'd0, out_if.valid}, 64'd1);
        chk("post_rst_sel", 64'(out_if.sel), 64'd1);
        drain();

        // Single request held under backpressure
        out_if.ready = 1'b0;
        set_req(1'b1, 4'd2, 4'b0100, 16'h0500, 16'h0000);
        cycle();
        in_if.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("single_valid", {63'd0, out_if.valid}, 64'd1);
            chk("single_sel", 64'(out_if.sel), 64'd2);
            chk("single_c2", 64'(out_if.c[11:8]), 64'd5);
            chk("single_b", 64'(out_if.b), 64'h4);
            cycle();
        end
        drain();

        // Backpressure: sel 0,1,2 back to back, two accepted
        out_if.ready = 1'b0;
        set_req(1'b1, 4'd0, 4'h1, 16'h1111, 16'h0);
        cycle();
        set_req(1'b1, 4'd1, 4'h2, 16'h2222, 16'h0);
        cycle();
        set_req(1'b1, 4'd2, 4'h4, 16'h3333, 16'h0);
        cycle();
        chk("bp_full_ready", {63'd0, in_if.ready}, 64'd0);
        chk("bp_head0", 64'(out_if.sel), 64'd0);
        out_if.ready = 1'b1;
        cycle();
        chk("bp_head1", 64'(out_if.sel), 64'd1);
        cycle();
        chk("bp_head2", 64'(out_if.sel), 64'd2);
        in_if.valid = 1'b0;
        cycle();
        chk("bp_empty", {63'd0, out_if.valid}, 64'd0);

        // Flush while FULL with a request offered
        out_if.ready = 1'b0;
        set_req(1'b1, 4'd1, 4'h1, 16'hAAAA, 16'h0);
        cycle();
        set_req(1'b1, 4'd3, 4'h8, 16'hBBBB, 16'h0);
        cycle();
        cnt_before = 32'(drop_cnt);
        flush = 1'b1;
        set_req(1'b1, 4'd0, 4'h1, 16'hCCCC, 16'h0);
        cycle();
        flush = 1'b0;
        in_if.valid = 1'b0;
        chk("flush_valid", {63'd0, out_if.valid}, 64'd0);
        chk("flush_ready", {63'd0, in_if.ready}, 64'd1);
        chk("flush_cnt", 64'(drop_cnt), 64'(cnt_before));
        cycle();
        chk("flush_absent", {63'd0, out_if.valid}, 64'd0);
        // Flush with one entry: same-cycle push discarded, out-of-range still counted
        set_req(1'b1, 4'd2, 4'h1, 16'h1010, 16'h0);
        cycle();
        cnt_before = 32'(drop_cnt);
        flush = 1'b1;
        set_req(1'b1, 4'd9, 4'h1, 16'h2020, 16'h0);
        cycle();
        flush = 1'b0;
        in_if.valid = 1'b0;
        chk("flush1_valid", {63'd0, out_if.valid}, 64'd0);
        chk("flush_oor_cnt", 64'(drop_cnt), 64'(cnt_before + 1));
        drain();

        // Out-of-range selector, counted from a clean counter
        reset_pulse();
        out_if.ready = 1'b0;
        set_req(1'b1, 4'd7, 4'h2, 16'h0000, 16'h9000);
        cycle();
        in_if.valid = 1'b0;
        chk("oor_cnt", 64'(drop_cnt), 64'd1);
`ifdef MUXREQ_SEL_CLAMP_EN
        chk("clamp_valid", {63'd0, out_if.valid}, 64'd1);
        chk("clamp_sel", 64'(out_if.sel), 64'd3);
        chk("clamp_e3", 64'(out_if.e[15:12]), 64'd9);
`else
        chk("drop_valid", {63'd0, out_if.valid}, 64'd0);
        chk("drop_ready", {63'd0, in_if.ready}, 64'd1);
`endif
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_if.valid = ($urandom_range(0, 9) < 7);
            in_if.sel   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15))
                                                      : 4'($urandom_range(0, 3));
            in_if.b     = 4'($urandom);
            in_if.b2    = 4'($urandom);
            in_if.c     = 16'($urandom);
            in_if.d     = 16'($urandom);
            in_if.e     = 16'($urandom);
            out_if.ready = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 15) == 0);
            cycle();
        end
        drain();

        // Counter saturation
        reset_pulse();
        out_if.ready = 1'b1;
        set_req(1'b1, 4'd7, 4'h1, 16'h0, 16'h0);
        repeat (300) cycle();
        in_if.valid = 1'b0;
        chk("sat_cnt", 64'(drop_cnt), 64'd255);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
